// File: rtl/line_transfer_unit.sv
// Cache-line transfer engine: moves BLOCK_WORDS words between the cache and a
// word-wide memory port, optionally chaining a victim writeback into a fill.
module line_transfer_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 64,
  parameter int BLOCK_WORDS = 16
) (
  input  logic                              clk,
  input  logic                              arstn,
  input  logic                              i_start_read,
  input  logic                              i_start_write,
  input  logic [ADDR_WIDTH-1:0]             i_fill_addr,
  input  logic [ADDR_WIDTH-1:0]             i_wb_addr,
  input  logic [BLOCK_WORDS*DATA_WIDTH-1:0] i_wb_block,
  output logic [BLOCK_WORDS*DATA_WIDTH-1:0] o_block,
  output logic                              o_busy,
  output logic                              o_done,
  output logic [ADDR_WIDTH-1:0]             o_mem_addr,
  output logic [DATA_WIDTH-1:0]             o_mem_data,
  output logic                              o_mem_write_en,
  input  logic [DATA_WIDTH-1:0]             i_mem_data,
  input  logic                              i_mem_access
);

  localparam int LW     = BLOCK_WORDS * DATA_WIDTH;
  localparam int IDX_W  = $clog2(BLOCK_WORDS);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int WORD_SH = $clog2(BYTES);
  localparam int OFF_W  = $clog2(BLOCK_WORDS * BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF_W;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    chain_q, chain_d;
  logic [ADDR_WIDTH-1:0]   wb_base_q, wb_base_d;
  logic [ADDR_WIDTH-1:0]   fill_base_q, fill_base_d;
  logic [LW-1:0]           wb_block_q, wb_block_d;
  logic [LW-1:0]           block_q, block_d;
  logic [ADDR_WIDTH-1:0]   word_off;
  logic                    last_word;

  assign word_off  = ADDR_WIDTH'(idx_q) << WORD_SH;
  assign last_word = &idx_q;
  assign o_block   = block_q;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    chain_d        = chain_q;
    wb_base_d      = wb_base_q;
    fill_base_d    = fill_base_q;
    wb_block_d     = wb_block_q;
    block_d        = block_q;
    o_busy         = 1'b0;
    o_done         = 1'b0;
    o_mem_addr     = '0;
    o_mem_data     = '0;
    o_mem_write_en = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Writeback wins when both arrive; the fill rides along as a chain.
        if (i_start_write) begin
          wb_base_d  = i_wb_addr & LINE_MASK;
          wb_block_d = i_wb_block;
          chain_d    = i_start_read;
          if (i_start_read) fill_base_d = i_fill_addr & LINE_MASK;
          idx_d      = '0;
          state_d    = S_WRITE;
        end else if (i_start_read) begin
          fill_base_d = i_fill_addr & LINE_MASK;
          chain_d     = 1'b0;
          idx_d       = '0;
          state_d     = S_READ;
        end
      end
      S_WRITE: begin
        o_busy         = 1'b1;
        o_mem_addr     = wb_base_q + word_off;
        o_mem_data     = wb_block_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
        o_mem_write_en = i_mem_access;
        if (i_mem_access) begin
          idx_d = idx_q + 1'b1;
          if (last_word) begin
            state_d = chain_q ? S_READ : S_DONE;
            chain_d = 1'b0;
          end
        end
      end
      S_READ: begin
        o_busy     = 1'b1;
        o_mem_addr = fill_base_q + word_off;
        if (i_mem_access) begin
          block_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = i_mem_data;
          idx_d = idx_q + 1'b1;
          if (last_word) state_d = S_DONE;
        end
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      chain_q     <= 1'b0;
      wb_base_q   <= '0;
      fill_base_q <= '0;
      wb_block_q  <= '0;
      block_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      chain_q     <= chain_d;
      wb_base_q   <= wb_base_d;
      fill_base_q <= fill_base_d;
      wb_block_q  <= wb_block_d;
      block_q     <= block_d;
    end
  end

endmodule

// File: tb/tb_line_transfer_unit.sv
// Bench for line_transfer_unit: directed and randomized line transfers against
// a word-level memory and a line-level model of expected bus traffic.
module tb_line_transfer_unit;

  localparam int DW = 32;
  localparam int AW = 64;
  localparam int BW = 16;
  localparam int LW = BW * DW;

  logic          clk = 1'b0;
  logic          arstn = 1'b0;
  logic          i_start_read = 1'b0;
  logic          i_start_write = 1'b0;
  logic [AW-1:0] i_fill_addr = '0;
  logic [AW-1:0] i_wb_addr = '0;
  logic [LW-1:0] i_wb_block = '0;
  logic [LW-1:0] o_block;
  logic          o_busy;
  logic          o_done;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_data;
  logic          o_mem_write_en;
  logic [DW-1:0] i_mem_data = '0;
  logic          i_mem_access = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [LW-1:0] blk_model = '0;

  line_transfer_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk(clk), .arstn(arstn),
    .i_start_read(i_start_read), .i_start_write(i_start_write),
    .i_fill_addr(i_fill_addr), .i_wb_addr(i_wb_addr), .i_wb_block(i_wb_block),
    .o_block(o_block), .o_busy(o_busy), .o_done(o_done),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_write_en(o_mem_write_en),
    .i_mem_data(i_mem_data), .i_mem_access(i_mem_access)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Unwritten memory holds 0x1000 + word number.
  function automatic logic [DW-1:0] memrd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h1000 + a[33:2];
  endfunction

  // mode: 0 strobe every cycle, 1 every 128th, 2 random, 3 first cycle then idle 300 cycles
  task automatic xfer(input bit rd, input bit wr, input logic [AW-1:0] fa, input logic [AW-1:0] wa,
                      input logic [LW-1:0] blk, input int mode, input bit inject, output int busy_cyc);
    logic [AW-1:0] fb, wb;
    logic [AW-1:0] eaddr[$];
    logic          ewe[$];
    logic [DW-1:0] edata[$];
    logic [LW-1:0] exp_blk;
    logic          acc;
    bit            seen;
    int            n, cyc;
    fb = fa & ~64'h3F;
    wb = wa & ~64'h3F;
    exp_blk = blk_model;
    for (int k = 0; k < BW; k++) if (wr) begin
      eaddr.push_back(wb + 64'(4 * k)); ewe.push_back(1'b1); edata.push_back(blk[k*DW +: DW]);
    end
    for (int k = 0; k < BW; k++) if (rd) begin
      eaddr.push_back(fb + 64'(4 * k)); ewe.push_back(1'b0);
      edata.push_back((wr && wb == fb) ? blk[k*DW +: DW] : memrd(fb + 64'(4 * k)));
      exp_blk[k*DW +: DW] = edata[edata.size()-1];
    end
    @(negedge clk);
    i_start_read = rd; i_start_write = wr; i_fill_addr = fa; i_wb_addr = wa; i_wb_block = blk;
    i_mem_access = 1'b0;
    @(negedge clk);
    i_start_read = 1'b0; i_start_write = 1'b0;
    n = 0; cyc = 0; busy_cyc = 0; seen = 1'b0;
    while (cyc < 6000) begin
      if (o_done) begin seen = 1'b1; break; end
      if (o_busy) busy_cyc++;
      i_mem_data = memrd(o_mem_addr);
      case (mode)
        0: acc = 1'b1;
        1: acc = (cyc % 128 == 127);
        2: acc = 1'($urandom_range(0, 1));
        default: acc = (cyc == 0) || (cyc > 300);
      endcase
      if (inject && cyc == 5) begin i_start_read = 1'b1; i_fill_addr = fa ^ 64'h1000; end
      else i_start_read = 1'b0;
      if (mode == 3 && cyc == 300) begin
        chk("stall_busy", LW'(o_busy), LW'(1'b1));
        chk("stall_addr", LW'(o_mem_addr), LW'(fb + 64'd4));
        chk("stall_word0", LW'(o_block[DW-1:0]), LW'(edata[0]));
      end
      i_mem_access = acc;
      #1;
      if (acc && n < eaddr.size()) begin
        chk("addr", LW'(o_mem_addr), LW'(eaddr[n]));
        chk("we", LW'(o_mem_write_en), LW'(ewe[n]));
        if (ewe[n]) begin
          chk("wdata", LW'(o_mem_data), LW'(edata[n]));
          mem[o_mem_addr] = o_mem_data;
        end
        n++;
      end else if (!acc) begin
        chk("we_idle", LW'(o_mem_write_en), LW'(1'b0));
      end
      @(negedge clk);
      cyc++;
    end
    i_mem_access = 1'b0; i_start_read = 1'b0;
    chk("done_seen", LW'(seen), LW'(1'b1));
    chk("access_count", LW'(n), LW'(eaddr.size()));
    chk("busy_at_done", LW'(o_busy), LW'(1'b0));
    chk("block", o_block, exp_blk);
    blk_model = exp_blk;
    @(negedge clk);
    chk("done_single", LW'(o_done), LW'(1'b0));
  endtask

  initial begin
    int bc;
    logic [LW-1:0] blk;
    #2;
    chk("rst_busy", LW'(o_busy), '0);
    chk("rst_done", LW'(o_done), '0);
    chk("rst_addr", LW'(o_mem_addr), '0);
    chk("rst_block", o_block, '0);
    @(negedge clk); arstn = 1'b1;

    // Fill, strobe every cycle
    xfer(1, 0, 64'h48, 64'h0, '0, 0, 0, bc);
    chk("fill_busy_cycles", LW'(bc), LW'(16));
    chk("fill_word0", LW'(o_block[31:0]), LW'(32'h1010));
    chk("fill_word15", LW'(o_block[15*DW +: DW]), LW'(32'h101F));

    // Writeback, strobe every 128th cycle
    for (int k = 0; k < BW; k++) blk[k*DW +: DW] = 32'hA0 + 32'(k);
    xfer(0, 1, 64'h0, 64'h100, blk, 1, 0, bc);
    for (int k = 0; k < BW; k++) chk("wb_mem", LW'(memrd(64'h100 + 64'(4 * k))), LW'(32'hA0 + 32'(k)));

    // Chained writeback + fill
    for (int k = 0; k < BW; k++) blk[k*DW +: DW] = $urandom;
    xfer(1, 1, 64'h300, 64'h200, blk, 0, 0, bc);
    chk("chain_busy_cycles", LW'(bc), LW'(32));

    // Ignored request mid-fill
    xfer(1, 0, 64'h7C4, 64'h0, '0, 0, 1, bc);
    repeat (4) begin
      @(negedge clk);
      chk("ign_idle_busy", LW'(o_busy), '0);
      chk("ign_no_done", LW'(o_done), '0);
    end
    chk("ign_block_held", o_block, blk_model);

    // Reset in the middle of a writeback
    for (int k = 0; k < BW; k++) blk[k*DW +: DW] = $urandom;
    @(negedge clk);
    i_start_write = 1'b1; i_wb_addr = 64'h500; i_wb_block = blk;
    @(negedge clk);
    i_start_write = 1'b0; i_mem_access = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1; mem[o_mem_addr] = o_mem_data;
      @(negedge clk);
    end
    i_mem_access = 1'b0;
    arstn = 1'b0;
    #1;
    chk("arst_busy", LW'(o_busy), '0);
    chk("arst_done", LW'(o_done), '0);
    chk("arst_addr", LW'(o_mem_addr), '0);
    chk("arst_data", LW'(o_mem_data), '0);
    chk("arst_we", LW'(o_mem_write_en), '0);
    chk("arst_block", o_block, '0);
    blk_model = '0;
    @(negedge clk); arstn = 1'b1;
    repeat (3) begin @(negedge clk); chk("arst_no_done", LW'(o_done), '0); end
    xfer(1, 0, 64'h504, 64'h0, '0, 0, 0, bc);
    chk("arst_partial_mem", LW'(o_block[4*DW +: DW]), LW'(blk[4*DW +: DW]));

    // First-cycle strobe then long stall
    xfer(1, 0, 64'h9A0, 64'h0, '0, 3, 0, bc);

    // Randomized transfers
    for (int t = 0; t < 12; t++) begin
      int r;
      logic [AW-1:0] fa, wa;
      r = $urandom_range(1, 3);
      for (int k = 0; k < BW; k++) blk[k*DW +: DW] = $urandom;
      fa = (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63)) | 64'h4000;
      wa = (64'($urandom_range(0, 3)) << 6) | 64'($urandom_range(0, 63)) | 64'h4000;
      xfer(r[0], r[1], fa, wa, blk, 2, 0, bc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
